ldpc_shift_scheduler: RTL and testbench
=======================================

Name: ldpc_shift_scheduler

Overview:
- Sequences the pipelined circular shifter across one QC-LDPC base matrix.
- Walks the base-matrix ROM row by row, skips null entries, and issues shift values with column/row tags to the shifter.
- Delays the tags by the shifter latency so they align with the rotated data at its output.
- Sits between the decoder control FSM and the shifter/message memories.

Parameters:
- MAXZ, 16, maximum expansion factor; shift width SHW = $clog2(MAXZ).
- NB_ROWS, 4, base-matrix rows (layers); RW = $clog2(NB_ROWS).
- NB_COLS, 8, base-matrix columns; CW = $clog2(NB_COLS).
- LAT, 4, shifter pipeline latency in cycles; must be at least 1.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- z_size  in  SHW+1  runtime expansion factor, 1..MAXZ; sampled at start.
- rom_en  out  1  ROM read enable; ROM holds rom_rdata when rom_en is low.
- rom_addr  out  RW+CW  row*NB_COLS+col.
- rom_rdata  in  1+SHW  {entry_valid, shift}; synchronous, 1-cycle latency.
- sh_valid  out  1  non-null entry presented to the shifter.
- sh_shift  out  SHW  shift value for the shifter.
- sh_col  out  CW  column of the presented entry.
- issue_ready  in  1  consumer accepts the presented entry.
- out_valid  out  1  tag aligned with shifter out_data.
- out_col  out  CW  column tag.
- out_row  out  RW  row tag.
- out_row_last  out  1  last non-null entry of its row.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse at end of pass.
- cfg_err  out  1  sticky range error; exists only with the optional feature.

Behaviour:
- Reset: all outputs 0, state IDLE, tag pipe cleared. Reset asserted mid-pass aborts immediately; no done pulse.
- States: IDLE -> RUN on start. RUN -> DRAIN after the last entry (row NB_ROWS-1, col NB_COLS-1) is consumed. DRAIN -> DONE after LAT cycles. DONE -> IDLE unconditionally.
- start outside IDLE is ignored.
- Fetch:
  - Start sampled in cycle t -> rom_en=1, rom_addr=0 in cycle t+1.
  - Address increments row-major, one entry per cycle, while not stalled.
- Present:
  - An entry fetched in cycle f appears on sh_* in cycle f+1. sh_* are driven combinationally from rom_rdata plus registered col/row/valid.
  - sh_valid = presented && entry_valid.
- Handshake:
  - Non-null entry is consumed when sh_valid && issue_ready.
  - Null entry is consumed unconditionally and never raises sh_valid.
  - Stall when sh_valid && !issue_ready: rom_en=0, rom_addr held, sh_* held stable until accepted.
- Tag pipe:
  - Each consumed non-null entry produces out_valid exactly LAT cycles after consumption, carrying its col, row and row-last flag.
  - out_row_last is resolved by lookahead: the flag is set on the previous non-null entry of the row when the row ends or the next row begins.
  - Rows with no non-null entries produce no tags.
- Drain/done:
  - DRAIN lasts exactly LAT cycles after the final consumption.
  - done pulses in the cycle after the final out_valid. If the matrix is all-null, done pulses LAT+1 cycles after the final consumption.
- Width rule: sh_shift is the ROM shift truncated to SHW bits; z_size is used only by the optional feature.

Optional Feature:
- Macro: LDPC_SCHED_RANGECHK_EN.
- Defined:
  - Any non-null entry with shift >= latched z_size sets sticky cfg_err; cfg_err is cleared only by reset or the next accepted start.
  - That entry is issued with sh_shift = 0.
  - z_size = 0 or z_size > MAXZ at start sets cfg_err; the pass still runs.
- Undefined:
  - No cfg_err port.
  - No comparison; shift passed through unchanged.

Decomposition:
- Package ldpc_sched_pkg:
  - typedef sched_state_e {IDLE, RUN, DRAIN, DONE}.
  - Packed struct rom_entry_t {valid, shift}.
  - Packed struct sched_tag_t {col, row, row_last}.
  - Width localparam helpers.
- One sub-module, ldpc_tag_delay:
  - LAT-deep valid+sched_tag_t shift register with asynchronous active-low reset.
  - Reused later for other latency-matched datapaths.

Test Plan:
- Setup: NB_ROWS=2, NB_COLS=4, LAT=4, all entries non-null, issue_ready=1, start at cycle 0.
  - rom_addr 0..7 in cycles 1..8; sh_valid cycles 2..9.
  - out_valid cycles 6..13; out_row_last at col 3 for both rows.
  - done pulses at cycle 14.
- Null skip: entries (0,1) and (1,2) null -> 6 sh_valid pulses. Tags are cols 0,2,3 then 0,1,3; sh_valid gaps where nulls are presented.
- Backpressure: issue_ready low for 3 cycles while entry 2 is presented.
  - sh_shift/sh_col held, rom_en=0, rom_addr=3 held.
  - Pass completes 3 cycles later than baseline; no entry lost or duplicated.
- Reset mid-pass: rst_n low at cycle 5, then start again.
  - All outputs 0 immediately, no done.
  - Fresh pass matches the baseline timing.
- start while busy: pulse start at cycle 4 -> ignored; exactly one done.
- With LDPC_SCHED_RANGECHK_EN, z_size=8, entry shift=11 -> sh_shift=0 and cfg_err=1, held until the next start.

Source files
------------

// File: rtl/ldpc_sched_pkg.sv
// ldpc_sched_pkg: shared FSM state, ROM entry and tag types plus width helpers for the LDPC shift scheduler.
package ldpc_sched_pkg;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_MAXZ = 16;
  localparam int DEF_NB_ROWS = 4;
  localparam int DEF_NB_COLS = 8;
  localparam int DEF_SHW = idx_w(DEF_MAXZ);
  localparam int DEF_RW = idx_w(DEF_NB_ROWS);
  localparam int DEF_CW = idx_w(DEF_NB_COLS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;
  typedef struct packed {
    logic valid;
    logic [DEF_SHW-1:0] shift;
  } rom_entry_t;
  typedef struct packed {
    logic [DEF_CW-1:0] col;
    logic [DEF_RW-1:0] row;
    logic row_last;
  } sched_tag_t;
endpackage

// File: rtl/ldpc_tag_delay.sv
// ldpc_tag_delay: LAT-deep valid+payload shift register for latency-matched side channels.
module ldpc_tag_delay
  import ldpc_sched_pkg::*;
#(
  parameter int LAT = 4,
  parameter type T = sched_tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  T     in_tag,
  output logic out_valid,
  output T     out_tag
);
  logic [LAT-1:0] v;
  T t [LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) t[i] <= '0;
    end else begin
      v <= LAT'({v, in_valid});
      t[0] <= in_tag;
      for (int i = 1; i < LAT; i++) t[i] <= t[i-1];
    end
  assign out_valid = v[LAT-1];
  assign out_tag = t[LAT-1];
endmodule

// File: rtl/ldpc_shift_scheduler.sv
// ldpc_shift_scheduler: walks the base-matrix ROM, issues non-null shifts and emits tags aligned to the shifter output.
// Define LDPC_SCHED_RANGECHK_EN to add the z_size range check and the sticky cfg_err output.
module ldpc_shift_scheduler
  import ldpc_sched_pkg::*;
#(
  parameter int MAXZ = 16,
  parameter int NB_ROWS = 4,
  parameter int NB_COLS = 8,
  parameter int LAT = 4,
  localparam int SHW = idx_w(MAXZ),
  localparam int RW = idx_w(NB_ROWS),
  localparam int CW = idx_w(NB_COLS)
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           start,
  input  logic [SHW:0]   z_size,
  output logic           rom_en,
  output logic [RW+CW-1:0] rom_addr,
  input  logic [SHW:0]   rom_rdata,
  output logic           sh_valid,
  output logic [SHW-1:0] sh_shift,
  output logic [CW-1:0]  sh_col,
  input  logic           issue_ready,
  output logic           out_valid,
  output logic [CW-1:0]  out_col,
  output logic [RW-1:0]  out_row,
  output logic           out_row_last,
  output logic           busy,
`ifdef LDPC_SCHED_RANGECHK_EN
  output logic           done,
  output logic           cfg_err
`else
  output logic           done
`endif
);
  typedef struct packed {
    logic valid;
    logic [SHW-1:0] shift;
  } entry_t;
  typedef struct packed {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic row_last;
  } tag_t;
  localparam int AW = RW + CW;
  localparam int GW = idx_w(LAT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NB_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NB_ROWS - 1);
  sched_state_e state, state_n;
  logic [RW-1:0] f_row, p_row;
  logic [CW-1:0] f_col, p_col;
  logic f_pend, p_valid, pend_live;
  logic [GW-1:0] drain_cnt, pend_age;
  logic [LAT-1:0] rl, rl_n;
  entry_t ent;
  tag_t in_tag, o_tag;
  logic take, consume, stall, fetch, final_take, patch;
  logic [SHW-1:0] shift_eff;
  assign ent = entry_t'(rom_rdata);
  assign take = p_valid && ent.valid && issue_ready;
  assign consume = p_valid && (!ent.valid || issue_ready);
  assign stall = p_valid && ent.valid && !issue_ready;
  assign fetch = state == RUN && f_pend && !stall;
  assign final_take = consume && p_row == ROW_LAST && p_col == COL_LAST;
  assign rom_en = fetch;
  assign rom_addr = AW'(f_row) * AW'(NB_COLS) + AW'(f_col);
  assign sh_valid = p_valid && ent.valid;
  assign sh_shift = p_valid ? shift_eff : '0;
  assign sh_col = p_valid ? p_col : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = final_take ? DRAIN : RUN;
      DRAIN:   state_n = drain_cnt == GW'(LAT - 1) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      f_row <= '0;
      f_col <= '0;
      f_pend <= 1'b0;
      p_valid <= 1'b0;
      p_row <= '0;
      p_col <= '0;
      drain_cnt <= '0;
      pend_live <= 1'b0;
      pend_age <= '0;
      rl <= '0;
    end else begin
      if (state == IDLE && start) begin
        f_row <= '0;
        f_col <= '0;
        f_pend <= 1'b1;
      end else if (fetch) begin
        f_col <= f_col == COL_LAST ? '0 : f_col + 1'b1;
        f_row <= f_col != COL_LAST ? f_row : (f_row == ROW_LAST ? '0 : f_row + 1'b1);
        f_pend <= !(f_col == COL_LAST && f_row == ROW_LAST);
      end
      if (fetch) begin
        p_valid <= 1'b1;
        p_row <= f_row;
        p_col <= f_col;
      end else if (consume) p_valid <= 1'b0;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      pend_live <= take ? p_col != COL_LAST : (consume && p_col == COL_LAST ? 1'b0 : pend_live);
      pend_age <= take ? '0 : (pend_age == GW'(LAT) ? pend_age : pend_age + 1'b1);
      rl <= rl_n;
    end
  // A row ending in nulls resolves its last issued tag late; pend_age is the pipe stage
  // holding that tag, so the flag is set in flight (possible while trailing nulls < LAT).
  assign patch = consume && !ent.valid && p_col == COL_LAST && pend_live && pend_age < GW'(LAT - 1);
  always_comb begin
    rl_n = rl << 1;
    for (int i = 0; i < LAT; i++)
      if (patch && int'(pend_age) + 1 == i) rl_n[i] = 1'b1;
  end
  assign in_tag = take ? tag_t'{p_col, p_row, p_col == COL_LAST} : '0;
  ldpc_tag_delay #(.LAT(LAT), .T(tag_t)) u_tag_delay (
    .clk(CLK),
    .rst_n(rst_n),
    .in_valid(take),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_tag(o_tag)
  );
  assign out_col = o_tag.col;
  assign out_row = o_tag.row;
  assign out_row_last = out_valid && (o_tag.row_last || rl[LAT-1]);
`ifdef LDPC_SCHED_RANGECHK_EN
  localparam logic [SHW:0] ZMAX = (SHW + 1)'(MAXZ);
  logic [SHW:0] z_lat;
  logic oob;
  assign oob = ent.valid && {1'b0, ent.shift} >= z_lat;
  assign shift_eff = oob ? '0 : ent.shift;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      z_lat <= '0;
      cfg_err <= 1'b0;
    end else if (state == IDLE && start) begin
      z_lat <= z_size;
      cfg_err <= z_size == '0 || z_size > ZMAX;
    end else if (p_valid && oob) cfg_err <= 1'b1;
`else
  logic unused_z;
  assign unused_z = ^z_size;
  assign shift_eff = ent.shift;
`endif
endmodule

// File: tb/tb_ldpc_shift_scheduler.sv
// tb_ldpc_shift_scheduler: scoreboard bench for a 2x4 base matrix with LAT=4; tags are pushed at start and popped by a monitor.
module tb_ldpc_shift_scheduler;
  logic clk = 1'b0;
  logic rst_n, start, issue_ready;
  logic [4:0] z_size, rom_rdata;
  logic rom_en, sh_valid, out_valid, out_row_last, busy, done;
  logic [2:0] rom_addr;
  logic [3:0] sh_shift;
  logic [1:0] sh_col, out_col;
  logic [0:0] out_row;
`ifdef LDPC_SCHED_RANGECHK_EN
  logic cfg_err;
`endif
  logic [4:0] mem [8];
  int cyc = 0, t0 = 0, checks = 0, failures = 0, n_done = 0;
  typedef struct {int col; int row; int last; int rel;} exp_t;
  exp_t sb[$];

  ldpc_shift_scheduler #(.MAXZ(16), .NB_ROWS(2), .NB_COLS(4), .LAT(4)) dut (
    .CLK(clk), .rst_n(rst_n), .start(start), .z_size(z_size),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .sh_valid(sh_valid), .sh_shift(sh_shift), .sh_col(sh_col), .issue_ready(issue_ready),
    .out_valid(out_valid), .out_col(out_col), .out_row(out_row), .out_row_last(out_row_last),
    .busy(busy),
`ifdef LDPC_SCHED_RANGECHK_EN
    .done(done), .cfg_err(cfg_err)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rom_en) rom_rdata <= mem[rom_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  function automatic int outs();
    return int'({rom_en, rom_addr, sh_valid, sh_shift, sh_col, out_valid, out_col, out_row, out_row_last, busy, done});
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected col=%0d row=%0d last=%0d exp=none", out_col, out_row, out_row_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_tag", out_col * 100 + out_row * 10 + out_row_last, e.col * 100 + e.row * 10 + e.last);
        chk("out_rel", cyc - t0, e.rel);
      end
    end
  end

  task automatic push(input int col, input int row, input int last, input int rel);
    exp_t e;
    e.col = col; e.row = row; e.last = last; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic push_base(input int stall_k, input int stall_len);
    for (int k = 0; k < 8; k++) push(k % 4, k / 4, k % 4 == 3, 6 + k + (k >= stall_k ? stall_len : 0));
  endtask

  task automatic load_mem(input logic [7:0] nm);
    for (int k = 0; k < 8; k++) mem[k] = nm[k] ? 5'd0 : {1'b1, 4'(k + 5)};
  endtask

  task automatic run_pass(input int lo_at, input int lo_len, input int done_exp, input int nvalid,
                          input int mode, input bit busy_start);
    int dn = 0, drel = -1, nv = 0;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= done_exp + 4; r++) begin
      @(posedge clk); #1;
      start = busy_start && r == 4;
      issue_ready = !(r >= lo_at && r < lo_at + lo_len);
      @(negedge clk);
      if (done) begin dn++; drel = r; end
      if (sh_valid && issue_ready) nv++;
      if (mode == 1 && r <= 10) begin
        chk("rom_en", rom_en, r <= 8);
        if (r <= 8) chk("rom_addr", rom_addr, r - 1);
        chk("sh_valid", sh_valid, r >= 2 && r <= 9);
        if (r >= 2 && r <= 9) begin
          chk("sh_shift", sh_shift, r + 3);
          chk("sh_col", sh_col, (r - 2) % 4);
        end
      end
      if (mode == 2 && r >= lo_at && r < lo_at + lo_len) begin
        chk("stall_sh", sh_valid * 100 + sh_col * 10 + sh_shift, 127);
        chk("stall_rom_en", rom_en, 0);
        chk("stall_rom_addr", rom_addr, 3);
      end
`ifdef LDPC_SCHED_RANGECHK_EN
      if (mode == 3 && r == 2) begin
        chk("range_shift", sh_shift, 0);
        chk("range_err", cfg_err, 1);
      end
`endif
    end
    chk("done_count", dn, 1);
    chk("done_rel", drel, done_exp);
    chk("issued", nv, nvalid);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; issue_ready = 1'b1; z_size = 5'd16;
    load_mem(8'h00);
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    push_base(8, 0);
    run_pass(99, 0, 14, 8, 1, 1'b0);
    load_mem(8'b0100_0010);
    push(0, 0, 0, 6); push(2, 0, 0, 8); push(3, 0, 1, 9);
    push(0, 1, 0, 10); push(1, 1, 0, 11); push(3, 1, 1, 13);
    run_pass(99, 0, 14, 6, 0, 1'b0);
    load_mem(8'h00);
    push_base(2, 3);
    run_pass(4, 3, 17, 8, 2, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    nd = n_done;
    #1 chk("abort_outs", outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    chk("abort_no_done", n_done - nd, 0);
    push_base(8, 0);
    run_pass(99, 0, 14, 8, 1, 1'b0);
    push_base(8, 0);
    run_pass(99, 0, 14, 8, 0, 1'b1);
    load_mem(8'hff);
    run_pass(99, 0, 14, 0, 0, 1'b0);
    load_mem(8'b1100_1000);
    push(0, 0, 0, 6); push(1, 0, 0, 7); push(2, 0, 1, 8);
    push(0, 1, 0, 10); push(1, 1, 1, 11);
    run_pass(99, 0, 14, 5, 0, 1'b0);
`ifdef LDPC_SCHED_RANGECHK_EN
    load_mem(8'h00);
    mem[0] = 5'b1_1011;
    z_size = 5'd8;
    push_base(8, 0);
    run_pass(99, 0, 14, 8, 3, 1'b0);
    chk("cfg_err_sticky", cfg_err, 1);
    z_size = 5'd16;
    load_mem(8'h00);
    push_base(8, 0);
    run_pass(99, 0, 14, 8, 0, 1'b0);
    chk("cfg_err_clear", cfg_err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
